mem_bus_arbiter: RTL and testbench

//  Shares the core's single AHB-lite-style memory master port between instruction fetch (IF) and

---
 rtl/mem_bus_arbiter_pkg.sv | 20 ++
 rtl/mem_bus_arbiter_if.sv | 41 ++++
 rtl/mem_bus_arbiter_grant_sel.sv | 18 +
 rtl/mem_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and bus encodings for the fetch / load-store memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic       HTRANS_IDLE   = 1'b0;
    localparam logic       HTRANS_NONSEQ = 1'b1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;
    localparam logic [2:0] HSIZE_DWORD   = 3'd3;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester handshakes plus the AHB-lite-style master bus; 'master' is the arbiter's view,
// 'slave' is the view of the pipeline requesters and the memory slave.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_done;
    logic              if_stall;

    logic              d_req;
    logic              d_write;
    logic [2:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              d_stall;

    logic [ADDR_W-1:0] HADDR;
    logic              HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADY;

    modport master (
        input  if_req, if_addr, d_req, d_write, d_size, d_addr, d_wdata, HRDATA, HREADY,
        output if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
               HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );

    modport slave (
        output if_req, if_addr, d_req, d_write, d_size, d_addr, d_wdata, HRDATA, HREADY,
        input  if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
               HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );
endinterface

// File: rtl/mem_bus_arbiter_grant_sel.sv
// Owner selection: load/store wins unless the starvation flag forces a waiting fetch through.
module arb_grant_sel
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  logic   starve,
    output logic   grant_valid,
    output owner_t grant_owner
);
    always_comb begin
        grant_valid = if_req | d_req;
        grant_owner = OWN_IF;
        if (d_req && !(starve && if_req)) begin
            grant_owner = OWN_D;
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding memory bus arbiter between fetch and load/store with registered bus outputs.
// Define FETCH_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT load/store grants.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
`ifdef FETCH_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic              CLK,
    input  logic              reset,
    mem_bus_arbiter_if.master bus
);
    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic              htrans_q, htrans_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;

    logic   grant_valid;
    owner_t grant_owner;
    logic   starve;
    logic   reissue_wait;
    logic   grant_fire;

    arb_grant_sel u_grant_sel (
        .if_req      (bus.if_req),
        .d_req       (bus.d_req),
        .starve      (starve),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // A requester whose done is showing still has its old payload on the pins; let it
    // present the next one before re-granting it, without letting the other side jump ahead.
    assign reissue_wait = (grant_owner == OWN_D) ? d_done_q : if_done_q;
    assign grant_fire   = (state_q == ARB_IDLE) && grant_valid && !reissue_wait;

`ifdef FETCH_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_fire) begin
            if (grant_owner == OWN_IF) begin
                starve_cnt_d = '0;
            end else if (bus.if_req && (starve_cnt_q != CNT_W'(STARVE_LIMIT))) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) starve_cnt_q <= '0;
        else       starve_cnt_q <= starve_cnt_d;
    end

    assign starve = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
`else
    assign starve = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        haddr_d    = haddr_q;
        htrans_d   = HTRANS_IDLE;
        hwrite_d   = hwrite_q;
        hsize_d    = hsize_q;
        hwdata_d   = hwdata_q;
        wdata_d    = wdata_q;
        d_rdata_d  = d_rdata_q;
        if_rdata_d = if_rdata_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (grant_fire) begin
                    state_d  = ARB_ADDR;
                    owner_d  = grant_owner;
                    htrans_d = HTRANS_NONSEQ;
                    if (grant_owner == OWN_D) begin
                        haddr_d  = bus.d_addr;
                        hwrite_d = bus.d_write;
                        hsize_d  = bus.d_size;
                        wdata_d  = bus.d_wdata;
                    end else begin
                        haddr_d  = bus.if_addr;
                        hwrite_d = 1'b0;
                        hsize_d  = HSIZE_WORD;
                        wdata_d  = '0;
                    end
                end
            end
            ARB_ADDR: begin
                state_d  = ARB_DATA;
                hwdata_d = wdata_q;
            end
            ARB_DATA: begin
                // Done is qualified by the live request so an abandoned transfer stays silent.
                if (bus.HREADY) begin
                    state_d = ARB_IDLE;
                    if (owner_q == OWN_D) begin
                        d_rdata_d = bus.HRDATA;
                        d_done_d  = bus.d_req;
                    end else begin
                        if_rdata_d = haddr_q[2] ? bus.HRDATA[63:32] : bus.HRDATA[31:0];
                        if_done_d  = bus.if_req;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_IF;
            haddr_q    <= '0;
            htrans_q   <= HTRANS_IDLE;
            hwrite_q   <= 1'b0;
            hsize_q    <= '0;
            hwdata_q   <= '0;
            wdata_q    <= '0;
            d_rdata_q  <= '0;
            if_rdata_q <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            haddr_q    <= haddr_d;
            htrans_q   <= htrans_d;
            hwrite_q   <= hwrite_d;
            hsize_q    <= hsize_d;
            hwdata_q   <= hwdata_d;
            wdata_q    <= wdata_d;
            d_rdata_q  <= d_rdata_d;
            if_rdata_q <= if_rdata_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
        end
    end

    assign bus.HADDR    = haddr_q;
    assign bus.HTRANS   = htrans_q;
    assign bus.HWRITE   = hwrite_q;
    assign bus.HSIZE    = hsize_q;
    assign bus.HWDATA   = hwdata_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.if_done  = if_done_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.d_done   = d_done_q;
    assign bus.if_stall = bus.if_req & ~if_done_q;
    assign bus.d_stall  = bus.d_req & ~d_done_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed timing scenarios plus randomized traffic checked every
// cycle against a transaction-level model of the arbitration and bus timing rules.
module tb_mem_bus_arbiter;
    localparam int STARVE_LIMIT = 4;
`ifdef FETCH_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_mis = 0;
    bit model_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_busy = 0, m_data_ph = 0, m_own_d = 0, m_write = 0;
    logic [63:0] m_addr = '0, m_wdata = '0;
    logic [2:0]  m_size = '0;
    bit          e_if_done = 0, e_d_done = 0, n_if_done, n_d_done;
    logic [31:0] e_if_rdata = '0;
    logic [63:0] e_d_rdata = '0;
    int          m_starve = 0;
    bit          m_force_if, win_d;

    always @(negedge clk) if (model_on) begin
        check("htrans", bus.HTRANS, m_busy && !m_data_ph);
        if (m_busy && !m_data_ph) begin
            check("haddr", bus.HADDR, m_addr);
            check("hwrite", bus.HWRITE, m_write);
            check("hsize", bus.HSIZE, m_size);
        end
        if (m_busy && m_data_ph) check("hwdata", bus.HWDATA, m_wdata);
        check("if_done", bus.if_done, e_if_done);
        check("d_done", bus.d_done, e_d_done);
        check("if_stall", bus.if_stall, bus.if_req && !e_if_done);
        check("d_stall", bus.d_stall, bus.d_req && !e_d_done);
        if (e_if_done) check("if_rdata", bus.if_rdata, e_if_rdata);
        if (e_d_done) check("d_rdata", bus.d_rdata, e_d_rdata);

        n_if_done = 0;
        n_d_done  = 0;
        if (reset) begin
            m_busy = 0; m_data_ph = 0; m_starve = 0;
        end else if (m_busy) begin
            if (!m_data_ph) begin
                m_data_ph = 1;
            end else if (bus.HREADY) begin
                m_busy = 0;
                if (m_own_d) begin
                    n_d_done  = bus.d_req;
                    e_d_rdata = bus.HRDATA;
                end else begin
                    n_if_done  = bus.if_req;
                    e_if_rdata = m_addr[2] ? bus.HRDATA[63:32] : bus.HRDATA[31:0];
                end
                $display("xfer %s addr=%h write=%0b done=%0b", m_own_d ? "MEM" : "IF ",
                         m_addr, m_write, n_if_done | n_d_done);
            end
        end else if (bus.if_req || bus.d_req) begin
            m_force_if = GUARD && bus.if_req && (m_starve >= STARVE_LIMIT);
            win_d      = bus.d_req && !m_force_if;
            // the just-completed requester is still showing stale payload this cycle
            if (!(win_d ? e_d_done : e_if_done)) begin
                m_busy = 1; m_data_ph = 0; m_own_d = win_d;
                if (win_d) begin
                    m_addr = bus.d_addr; m_write = bus.d_write;
                    m_size = bus.d_size; m_wdata = bus.d_wdata;
                    if (bus.if_req && m_starve < STARVE_LIMIT) m_starve++;
                end else begin
                    m_addr = bus.if_addr; m_write = 0; m_size = 3'd2; m_wdata = '0;
                    m_starve = 0;
                end
            end
        end
        e_if_done = n_if_done;
        e_d_done  = n_d_done;
    end

    // ---------------- stimulus ----------------
    int  n_d;
    bit  seen_if;

    initial begin
        reset = 1;
        bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_write = 0; bus.d_size = 3'd3; bus.d_addr = '0; bus.d_wdata = '0;
        bus.HREADY = 1; bus.HRDATA = '0;
        repeat (2) tick();
        model_on = 1;
        check("rst_htrans", bus.HTRANS, 0);
        check("rst_haddr", bus.HADDR, 0);
        check("rst_hsize", bus.HSIZE, 0);
        check("rst_hwrite", bus.HWRITE, 0);
        check("rst_hwdata", bus.HWDATA, 0);
        check("rst_dones", {bus.if_done, bus.d_done}, 0);
        check("rst_rdata", bus.d_rdata | {32'h0, bus.if_rdata}, 0);
        tick();
        reset = 0;
        repeat (2) tick();

        // fetch only, then re-issue holding the request with a new PC
        bus.if_req = 1; bus.if_addr = 64'h1000; bus.HRDATA = 64'hDEAD_BEEF_0000_0013;
        tick();
        check("t1_htrans_c1", bus.HTRANS, 1);
        check("t1_haddr", bus.HADDR, 64'h1000);
        check("t1_hsize", bus.HSIZE, 3'd2);
        tick();
        check("t1_htrans_c2", bus.HTRANS, 0);
        tick();
        check("t1_if_done_c3", bus.if_done, 1);
        check("t1_if_rdata_lo", bus.if_rdata, 32'h0000_0013);
        bus.if_addr = 64'h1004;
        tick();
        check("t1_no_overlap", bus.HTRANS, 0);
        tick();
        check("t1_haddr_2", bus.HADDR, 64'h1004);
        repeat (2) tick();
        check("t1_if_done_2", bus.if_done, 1);
        check("t1_if_rdata_hi", bus.if_rdata, 32'hDEAD_BEEF);
        bus.if_req = 0;
        repeat (3) tick();

        // simultaneous requests: store first, fetch right after
        bus.if_req = 1; bus.if_addr = 64'h3000;
        bus.d_req = 1; bus.d_write = 1; bus.d_size = 3'd3; bus.d_addr = 64'h2000; bus.d_wdata = 64'h55;
        tick();
        check("t2_hwrite", bus.HWRITE, 1);
        check("t2_haddr", bus.HADDR, 64'h2000);
        tick();
        check("t2_hwdata", bus.HWDATA, 64'h55);
        tick();
        check("t2_d_done", bus.d_done, 1);
        check("t2_if_stall", bus.if_stall, 1);
        bus.d_req = 0;
        tick();
        check("t2_if_addr_phase", {bus.HTRANS, bus.HADDR}, {1'b1, 64'h3000});
        tick();
        check("t2_if_done_early", bus.if_done, 0);
        tick();
        check("t2_if_done", bus.if_done, 1);
        bus.if_req = 0;
        repeat (3) tick();

        // load with a three-cycle wait state
        bus.d_req = 1; bus.d_write = 0; bus.d_addr = 64'h4000;
        tick();
        for (int c = 0; c < 4; c++) begin
            tick();
            bus.HREADY = (c == 3);
            if (c == 3) bus.HRDATA = 64'h1122_3344_5566_7788;
            check("t3_haddr_held", bus.HADDR, 64'h4000);
            check("t3_stall", {bus.d_stall, bus.d_done}, 2'b10);
        end
        tick();
        check("t3_d_done", bus.d_done, 1);
        check("t3_d_rdata", bus.d_rdata, 64'h1122_3344_5566_7788);
        bus.d_req = 0;
        repeat (3) tick();

        // reset during the data phase, request re-issued afterwards
        bus.d_req = 1; bus.d_addr = 64'h7000;
        tick();
        tick();
        bus.HREADY = 0; reset = 1;
        tick();
        reset = 0; bus.HREADY = 1;
        check("t4_rst_abort", {bus.HTRANS, bus.d_done, bus.HADDR}, '0);
        tick();
        check("t4_reissue", {bus.HTRANS, bus.HADDR}, {1'b1, 64'h7000});
        repeat (2) tick();
        check("t4_d_done", bus.d_done, 1);
        bus.d_req = 0;
        repeat (3) tick();

        // fetch abandoned mid data phase
        bus.if_req = 1; bus.if_addr = 64'h8000;
        tick();
        tick();
        bus.HREADY = 0; bus.if_req = 0;
        tick();
        bus.HREADY = 1;
        tick();
        check("t6_no_done", {bus.if_done, bus.HTRANS}, 0);
        tick();
        check("t6_idle", {bus.if_done, bus.HTRANS}, 0);
        repeat (2) tick();

        // continuous load/store traffic against a waiting fetch
        bus.if_req = 1; bus.if_addr = 64'h5000;
        bus.d_req = 1; bus.d_write = 0; bus.d_addr = 64'h6000;
        n_d = 0; seen_if = 0;
`ifdef FETCH_STARVE_GUARD_EN
        for (int c = 0; c < 200 && !seen_if; c++) begin
            tick();
            if (bus.if_done) seen_if = 1;
            else if (bus.d_done) begin n_d++; bus.d_addr = bus.d_addr + 8; end
        end
        check("t5_if_granted", seen_if, 1);
        check("t5_mem_before_if", n_d, STARVE_LIMIT);
        bus.if_req = 0; bus.d_req = 0;
`else
        for (int c = 0; c < 400 && n_d < 20; c++) begin
            tick();
            if (bus.if_done) seen_if = 1;
            if (bus.d_done) begin n_d++; bus.d_addr = bus.d_addr + 8; end
        end
        check("t5_mem_xfers", n_d, 20);
        check("t5_if_starved", seen_if, 0);
        bus.d_req = 0;
        for (int c = 0; c < 20 && !seen_if; c++) begin
            tick();
            if (bus.if_done) seen_if = 1;
        end
        check("t5_if_after_mem", seen_if, 1);
        bus.if_req = 0;
`endif
        repeat (3) tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset      = ($urandom_range(0, 499) == 0);
            bus.HREADY = ($urandom_range(0, 3) != 0);
            bus.HRDATA = {$urandom, $urandom};
            if (!bus.if_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.if_req = 1; bus.if_addr = {32'h0, $urandom & 32'hFFFF_FFFC};
                end
            end else if (bus.if_done) begin
                if ($urandom_range(0, 2) == 0) bus.if_req = 0;
                else bus.if_addr = {32'h0, $urandom & 32'hFFFF_FFFC};
            end else if ($urandom_range(0, 63) == 0) begin
                bus.if_req = 0;
            end
            if (!bus.d_req || bus.d_done) begin
                if (bus.d_done && $urandom_range(0, 2) == 0) begin
                    bus.d_req = 0;
                end else if (bus.d_done || $urandom_range(0, 2) == 0) begin
                    bus.d_req = 1; bus.d_write = $urandom_range(0, 1);
                    bus.d_size = 3'($urandom_range(0, 3));
                    bus.d_addr = {$urandom, $urandom}; bus.d_wdata = {$urandom, $urandom};
                end
            end else if ($urandom_range(0, 63) == 0) begin
                bus.d_req = 0;
            end
        end
        reset = 0; bus.if_req = 0; bus.d_req = 0; bus.HREADY = 1;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
